// File: rtl/scaler_h_mch.sv
// rtl/scaler_h_mch.sv - multi-channel horizontal polyphase scaler with shared phase accumulator
module scaler_h_mch #(
    parameter int SCALE_STEP  = 4096,
    parameter int CH_COUNT    = 3,
    parameter int PIXEL_WIDTH = 8,
    parameter int COE_WIDTH   = 10,
    parameter int TAP_COUNT   = 4,
    parameter int COE_PHASES  = 1024,
    parameter int EDGE_MODE   = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [15:0]                         scale_step_i,
    output logic                                coe_adr_en,
    output logic [$clog2(COE_PHASES)-1:0]       coe_adr,
    input  logic [TAP_COUNT*COE_WIDTH-1:0]      coe_i,
    input  logic [CH_COUNT*PIXEL_WIDTH-1:0]     di_i,
    input  logic                                de_i,
    input  logic                                hs_i,
    input  logic                                vs_i,
    output logic [CH_COUNT*PIXEL_WIDTH-1:0]     do_o,
    output logic                                de_o,
    output logic                                hs_o,
    output logic                                vs_o,
    output logic                                err_overrun
);

    localparam int ACC_W   = 24;
    localparam int ADR_W   = $clog2(COE_PHASES);
    localparam int FRAC_SH = $clog2(SCALE_STEP / COE_PHASES);
    localparam int DW      = CH_COUNT * PIXEL_WIDTH;
    localparam int PROD_W  = COE_WIDTH + PIXEL_WIDTH + 1;
    localparam int SUM_W   = PROD_W + $clog2(TAP_COUNT);
    localparam int RND_W   = SUM_W + 1;
    localparam int FILL_W  = $clog2(TAP_COUNT + 1);
    localparam int SH      = COE_WIDTH - 2;

    localparam logic        [ACC_W-1:0]  STEP_U   = ACC_W'(SCALE_STEP);
    localparam logic signed [ACC_W-1:0]  STEP_S   = ACC_W'(SCALE_STEP);
    localparam logic signed [RND_W-1:0]  RND_C    = RND_W'(1 << (COE_WIDTH - 3));
    localparam logic signed [RND_W-1:0]  PIX_MAX  = RND_W'((1 << PIXEL_WIDTH) - 1);
    localparam logic        [FILL_W-1:0] FILL_MAX = FILL_W'(TAP_COUNT);

    // control state
    logic                hs_q;
    logic                line_act_q, line_act_d;
    logic [ACC_W-1:0]    acc_i_q, acc_i_d;
    logic [ACC_W-1:0]    acc_o_q, acc_o_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                err_q, err_d;
    logic                line_start, emit, accept;
    logic signed [ACC_W-1:0] lead;

    // window and capture
    logic [DW-1:0]       win_q   [TAP_COUNT];
    logic [DW-1:0]       first_q;
    logic [DW-1:0]       eff     [TAP_COUNT];
    logic [DW-1:0]       cap_q   [TAP_COUNT];
    logic [ADR_W-1:0]    coe_adr_q;
    logic                coe_en_q;

    // arithmetic pipeline
    logic signed [PROD_W-1:0] prod_d [CH_COUNT][TAP_COUNT];
    logic signed [PROD_W-1:0] prod_q [CH_COUNT][TAP_COUNT];
    logic                     v2_q;
    logic signed [SUM_W-1:0]  sum_d  [CH_COUNT];
    logic signed [SUM_W-1:0]  sum_q  [CH_COUNT];
    logic                     v3_q;
    logic signed [RND_W-1:0]  rnd    [CH_COUNT];
    logic signed [RND_W-1:0]  rsh    [CH_COUNT];
    logic [DW-1:0]            do_d;
    logic [DW-1:0]            do_q;
    logic                     de_q;
    logic [3:0]               hs_dly_q;
    logic [3:0]               vs_dly_q;

    // Line start, accept and emission decisions plus accumulator next state;
    // a line start overrides the counters after any emission it coincides with.
    always_comb begin
        line_start = hs_i & ~hs_q;
        emit       = line_act_q & (acc_i_q > acc_o_q);
        accept     = de_i & line_act_q & ~line_start;
        acc_i_d    = acc_i_q;
        acc_o_d    = acc_o_q;
        fill_d     = fill_q;
        line_act_d = line_act_q;
        err_d      = err_q;
        lead       = '0;
        if (emit) begin
            acc_o_d = acc_o_q + ACC_W'(scale_step_i);
        end
        if (accept) begin
            acc_i_d = acc_i_q + STEP_U;
            if (fill_q < FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            lead = $signed(acc_i_d - acc_o_d);
            if (lead > STEP_S) begin
                err_d = 1'b1;
            end
        end
        if (line_start) begin
            acc_i_d    = '0;
            acc_o_d    = STEP_U;
            fill_d     = '0;
            line_act_d = 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q       <= 1'b0;
            line_act_q <= 1'b0;
            acc_i_q    <= '0;
            acc_o_q    <= '0;
            fill_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            hs_q       <= hs_i;
            line_act_q <= line_act_d;
            acc_i_q    <= acc_i_d;
            acc_o_q    <= acc_o_d;
            fill_q     <= fill_d;
            err_q      <= err_d;
        end
    end

    // Taps not yet filled on this line read zero or the line's first pixel
    always_comb begin
        for (int k = 0; k < TAP_COUNT; k++) begin
            if (FILL_W'(k) < fill_q) begin
                eff[k] = win_q[k];
            end else if (EDGE_MODE != 0) begin
                eff[k] = first_q;
            end else begin
                eff[k] = '0;
            end
        end
    end

    // Pixel window shift, first-pixel latch, and capture with phase fetch on emission
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < TAP_COUNT; k++) begin
                win_q[k] <= '0;
                cap_q[k] <= '0;
            end
            first_q   <= '0;
            coe_adr_q <= '0;
            coe_en_q  <= 1'b0;
        end else begin
            if (accept) begin
                win_q[0] <= di_i;
                for (int k = 1; k < TAP_COUNT; k++) begin
                    win_q[k] <= win_q[k-1];
                end
                if (fill_q == '0) begin
                    first_q <= di_i;
                end
            end
            if (emit) begin
                for (int k = 0; k < TAP_COUNT; k++) begin
                    cap_q[k] <= eff[k];
                end
                coe_adr_q <= acc_o_q[FRAC_SH +: ADR_W];
            end
            coe_en_q <= emit;
        end
    end

    // Signed products of shared coefficients with each channel's captured taps
    always_comb begin
        for (int c = 0; c < CH_COUNT; c++) begin
            for (int t = 0; t < TAP_COUNT; t++) begin
                prod_d[c][t] = PROD_W'($signed(coe_i[t*COE_WIDTH +: COE_WIDTH]))
                             * PROD_W'($signed({1'b0, cap_q[t][c*PIXEL_WIDTH +: PIXEL_WIDTH]}));
            end
        end
    end

    // Per-channel tap sum
    always_comb begin
        for (int c = 0; c < CH_COUNT; c++) begin
            sum_d[c] = '0;
            for (int t = 0; t < TAP_COUNT; t++) begin
                sum_d[c] = sum_d[c] + SUM_W'(prod_q[c][t]);
            end
        end
    end

    // Round to nearest and clamp into the unsigned pixel range
    always_comb begin
        do_d = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            rnd[c] = RND_W'(sum_q[c]) + RND_C;
            rsh[c] = rnd[c] >>> SH;
            if (rsh[c][RND_W-1]) begin
                do_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
            end else if (rsh[c] > PIX_MAX) begin
                do_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] = '1;
            end else begin
                do_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] = rsh[c][PIXEL_WIDTH-1:0];
            end
        end
    end

    // Three-stage arithmetic pipeline and sync delay line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_COUNT; c++) begin
                for (int t = 0; t < TAP_COUNT; t++) begin
                    prod_q[c][t] <= '0;
                end
                sum_q[c] <= '0;
            end
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            do_q     <= '0;
            de_q     <= 1'b0;
            hs_dly_q <= '0;
            vs_dly_q <= '0;
        end else begin
            for (int c = 0; c < CH_COUNT; c++) begin
                for (int t = 0; t < TAP_COUNT; t++) begin
                    prod_q[c][t] <= prod_d[c][t];
                end
                sum_q[c] <= sum_d[c];
            end
            v2_q <= coe_en_q;
            v3_q <= v2_q;
            de_q <= v3_q;
            if (v3_q) begin
                do_q <= do_d;
            end
            hs_dly_q <= {hs_dly_q[2:0], hs_i};
            vs_dly_q <= {vs_dly_q[2:0], vs_i};
        end
    end

    assign coe_adr_en  = coe_en_q;
    assign coe_adr     = coe_adr_q;
    assign do_o        = do_q;
    assign de_o        = de_q;
    assign hs_o        = hs_dly_q[3];
    assign vs_o        = vs_dly_q[3];
    assign err_overrun = err_q;

endmodule

// File: tb/tb_scaler_h_mch.sv
// tb/tb_scaler_h_mch.sv - directed self-checking bench for scaler_h_mch
module tb_scaler_h_mch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] scale_step = 16'd4096;
    logic [39:0] coe = '0;
    logic [23:0] di = '0;
    logic        de = 1'b0, hs = 1'b0, vs = 1'b0;

    logic        coe_adr_en0, coe_adr_en1;
    logic [9:0]  coe_adr0, coe_adr1;
    logic [23:0] do0, do1;
    logic        de_o0, de_o1, hs_o0, hs_o1, vs_o0, vs_o1, err0, err1;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [23:0] out0_q[$];
    logic [23:0] out1_q[$];
    int          out0_t[$];
    logic [9:0]  adr_q[$];
    logic [9:0]  adr1_q[$];
    int          adr_t[$];

    always #5 clk = ~clk;

    scaler_h_mch #(.EDGE_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .scale_step_i(scale_step),
        .coe_adr_en(coe_adr_en0), .coe_adr(coe_adr0), .coe_i(coe),
        .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
        .do_o(do0), .de_o(de_o0), .hs_o(hs_o0), .vs_o(vs_o0),
        .err_overrun(err0)
    );

    scaler_h_mch #(.EDGE_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .scale_step_i(scale_step),
        .coe_adr_en(coe_adr_en1), .coe_adr(coe_adr1), .coe_i(coe),
        .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
        .do_o(do1), .de_o(de_o1), .hs_o(hs_o1), .vs_o(vs_o1),
        .err_overrun(err1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (de_o0) begin
            out0_q.push_back(do0);
            out0_t.push_back(cyc);
        end
        if (de_o1) out1_q.push_back(do1);
        if (coe_adr_en0) begin
            adr_q.push_back(coe_adr0);
            adr_t.push_back(cyc);
        end
        if (coe_adr_en1) adr1_q.push_back(coe_adr1);
    end

    function automatic logic [39:0] taps(input int t0, input int t1, input int t2, input int t3);
        logic [39:0] v;
        v[9:0]   = 10'(t0);
        v[19:10] = 10'(t1);
        v[29:20] = 10'(t2);
        v[39:30] = 10'(t3);
        return v;
    endfunction

    function automatic logic [23:0] pix3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic clear_q();
        out0_q.delete(); out1_q.delete(); out0_t.delete();
        adr_q.delete(); adr1_q.delete(); adr_t.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic start_line();
        @(negedge clk);
        hs = 1'b1; de = 1'b0;
        @(negedge clk);
        hs = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        de = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; hs = 1'b1; vs = 1'b1; de = 1'b1; di = 24'hffffff;
        coe = taps(0, 256, 0, 0);
        repeat (3) @(negedge clk);
        tests_run++; if (do0 !== 24'h0) begin tests_failed++; $display("FAIL reset_do: got %h want 000000", do0); end
        tests_run++; if ({de_o0, hs_o0, vs_o0} !== 3'b000) begin tests_failed++; $display("FAIL reset_strobes: got %b want 000", {de_o0, hs_o0, vs_o0}); end
        tests_run++; if (coe_adr_en0 !== 1'b0) begin tests_failed++; $display("FAIL reset_coe_en: got %b want 0", coe_adr_en0); end
        tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err0); end
        tests_run++; if ({do1, de_o1, hs_o1, vs_o1, coe_adr_en1, err1} !== 29'h0) begin
            tests_failed++; $display("FAIL reset_dut1: got do=%h de=%b hs=%b vs=%b en=%b err=%b want all 0", do1, de_o1, hs_o1, vs_o1, coe_adr_en1, err1);
        end
        rst_n = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
        repeat (6) @(negedge clk);
        clear_q();
    endtask

    task automatic test_sync_delay();
        logic expv;
        do_reset();
        @(negedge clk);
        hs = 1'b1; vs = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin hs = 1'b0; vs = 1'b0; end
            expv = (k == 4);
            tests_run++; if (hs_o0 !== expv || vs_o0 !== expv) begin
                tests_failed++; $display("FAIL sync_delay k=%0d: got hs=%b vs=%b want %b", k, hs_o0, vs_o0, expv);
            end
        end
        drain();
    endtask

    task automatic test_unity();
        do_reset();
        scale_step = 16'd4096; coe = taps(0, 256, 0, 0);
        start_line();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); de = 1'b1; di = pix3(i, i + 100, 200 - i);
        end
        drain();
        tests_run++; if (out0_q.size() !== 9) begin tests_failed++; $display("FAIL unity_count: got %0d want 9", out0_q.size()); end
        for (int j = 0; j < 9; j++) begin
            if (j < out0_q.size() && j < adr_t.size()) begin
                tests_run++; if (out0_q[j] !== pix3(j, j + 100, 200 - j)) begin
                    tests_failed++; $display("FAIL unity_val[%0d]: got %h want %h", j, out0_q[j], pix3(j, j + 100, 200 - j));
                end
                tests_run++; if (out0_t[j] - adr_t[j] !== 3) begin
                    tests_failed++; $display("FAIL unity_lat[%0d]: got %0d want 3", j, out0_t[j] - adr_t[j]);
                end
            end
        end
        tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("FAIL unity_err: got %b want 0", err0); end
    endtask

    task automatic test_downscale();
        do_reset();
        scale_step = 16'd8192; coe = taps(0, 256, 0, 0);
        start_line();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); de = 1'b1; di = pix3(i, i + 100, 200 - i);
        end
        drain();
        tests_run++; if (out0_q.size() !== 10) begin tests_failed++; $display("FAIL down2_count: got %0d want 10", out0_q.size()); end
        tests_run++; if (adr_q.size() !== 10) begin tests_failed++; $display("FAIL down2_adr_count: got %0d want 10", adr_q.size()); end
        for (int k = 0; k < 10; k++) begin
            if (k < adr_q.size()) begin
                tests_run++; if (adr_q[k] !== 10'd0) begin tests_failed++; $display("FAIL down2_adr[%0d]: got %0d want 0", k, adr_q[k]); end
            end
            if (k < out0_q.size()) begin
                tests_run++; if (out0_q[k] !== pix3(2 * k, 2 * k + 100, 200 - 2 * k)) begin
                    tests_failed++; $display("FAIL down2_val[%0d]: got %h want %h", k, out0_q[k], pix3(2 * k, 2 * k + 100, 200 - 2 * k));
                end
            end
        end
        // 1.5:1 step walks the phase between 0 and half a pixel
        do_reset();
        scale_step = 16'd6144;
        start_line();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); de = 1'b1; di = pix3(i, i, i);
        end
        drain();
        tests_run++; if (adr_q.size() !== 8) begin tests_failed++; $display("FAIL down15_adr_count: got %0d want 8", adr_q.size()); end
        for (int k = 0; k < 8; k++) begin
            if (k < adr_q.size() && k < adr1_q.size()) begin
                tests_run++; if (adr_q[k] !== ((k % 2) ? 10'd512 : 10'd0) || adr1_q[k] !== adr_q[k]) begin
                    tests_failed++; $display("FAIL down15_adr[%0d]: got %0d/%0d want %0d", k, adr_q[k], adr1_q[k], (k % 2) ? 512 : 0);
                end
            end
        end
    endtask

    task automatic test_clamp();
        int          tv[3];
        logic [23:0] iv[3];
        logic [23:0] ev[3];
        tv[0] = 384;  iv[0] = pix3(200, 100, 0); ev[0] = pix3(255, 150, 0);
        tv[1] = -256; iv[1] = pix3(100, 0, 1);   ev[1] = pix3(0, 0, 0);
        tv[2] = 128;  iv[2] = pix3(3, 4, 255);   ev[2] = pix3(2, 2, 128);
        for (int s = 0; s < 3; s++) begin
            do_reset();
            scale_step = 16'd4096; coe = taps(tv[s], 0, 0, 0);
            start_line();
            for (int i = 0; i < 5; i++) begin
                @(negedge clk); de = 1'b1; di = iv[s];
            end
            drain();
            tests_run++; if (out0_q.size() !== 4) begin tests_failed++; $display("FAIL clamp%0d_count: got %0d want 4", s, out0_q.size()); end
            for (int j = 0; j < out0_q.size(); j++) begin
                tests_run++; if (out0_q[j] !== ev[s]) begin
                    tests_failed++; $display("FAIL clamp%0d_val[%0d]: got %h want %h", s, j, out0_q[j], ev[s]);
                end
            end
        end
    endtask

    task automatic test_edge();
        int e0[5];
        int e1[5];
        e0 = '{0, 0, 50, 60, 70};
        e1 = '{50, 50, 50, 60, 70};
        do_reset();
        scale_step = 16'd4096; coe = taps(0, 0, 0, 256);
        start_line();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); de = 1'b1; di = pix3(50 + 10 * i, 50 + 10 * i, 50 + 10 * i);
        end
        drain();
        tests_run++; if (out0_q.size() !== 5 || out1_q.size() !== 5) begin
            tests_failed++; $display("FAIL edge_count: got %0d/%0d want 5/5", out0_q.size(), out1_q.size());
        end
        for (int k = 0; k < 5; k++) begin
            if (k < out0_q.size() && k < out1_q.size()) begin
                tests_run++; if (out0_q[k] !== pix3(e0[k], e0[k], e0[k])) begin
                    tests_failed++; $display("FAIL edge0_val[%0d]: got %h want %h", k, out0_q[k], pix3(e0[k], e0[k], e0[k]));
                end
                tests_run++; if (out1_q[k] !== pix3(e1[k], e1[k], e1[k])) begin
                    tests_failed++; $display("FAIL edge1_val[%0d]: got %h want %h", k, out1_q[k], pix3(e1[k], e1[k], e1[k]));
                end
            end
        end
    endtask

    task automatic test_channels();
        do_reset();
        scale_step = 16'd4096; coe = taps(0, 256, 0, 0);
        start_line();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); de = 1'b1; di = pix3(10, 20, 30);
        end
        drain();
        tests_run++; if (out0_q.size() !== 5) begin tests_failed++; $display("FAIL chan_count: got %0d want 5", out0_q.size()); end
        for (int j = 0; j < out0_q.size(); j++) begin
            tests_run++; if (out0_q[j] !== 24'h1e140a) begin
                tests_failed++; $display("FAIL chan_val[%0d]: got %h want 1e140a", j, out0_q[j]);
            end
        end
    endtask

    task automatic test_overrun_reset();
        do_reset();
        scale_step = 16'd1024; coe = taps(0, 256, 0, 0);
        start_line();
        @(negedge clk); de = 1'b1; di = pix3(0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 2) begin
                tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("FAIL overrun_early: got %b want 0", err0); end
            end
            if (i == 3) begin
                tests_run++; if (err0 !== 1'b1) begin tests_failed++; $display("FAIL overrun_set: got %b want 1", err0); end
            end
            if (i < 6) di = pix3(i, i, i);
        end
        tests_run++; if (err0 !== 1'b1) begin tests_failed++; $display("FAIL overrun_sticky: got %b want 1", err0); end
        tests_run++; if (de_o0 !== 1'b1) begin tests_failed++; $display("FAIL busy_before_reset: got %b want 1", de_o0); end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++; if (de_o0 !== 1'b0) begin tests_failed++; $display("FAIL midreset_de: got %b want 0", de_o0); end
        tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("FAIL midreset_err: got %b want 0", err0); end
        rst_n = 1'b1;
        clear_q();
        repeat (10) @(negedge clk);
        tests_run++; if (out0_q.size() !== 0 || adr_q.size() !== 0) begin
            tests_failed++; $display("FAIL no_emit_after_reset: got %0d outputs %0d fetches want 0", out0_q.size(), adr_q.size());
        end
        scale_step = 16'd4096;
        start_line();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); de = 1'b1; di = pix3(i, i, i);
        end
        drain();
        tests_run++; if (out0_q.size() !== 3) begin tests_failed++; $display("FAIL emit_after_hs: got %0d want 3", out0_q.size()); end
        // one pixel every fourth cycle keeps exact pace with a 1/4 step
        do_reset();
        scale_step = 16'd1024;
        start_line();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk); de = (c % 4 == 0); di = pix3(c, c, c);
        end
        drain();
        tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("FAIL duty_no_overrun: got %b want 0", err0); end
        tests_run++; if (out0_q.size() == 0) begin tests_failed++; $display("FAIL duty_outputs: got 0 want >0"); end
    endtask

    initial begin
        test_reset();
        test_sync_delay();
        test_unity();
        test_downscale();
        test_clamp();
        test_edge();
        test_channels();
        test_overrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish before 500000");
        $fatal(1);
    end

endmodule

// File: doc/scaler_h_mch.md
Name: scaler_h_mch

Overview:
Next-generation horizontal polyphase scaler for the video scaler2 path. It handles CH_COUNT parallel colour channels that share one phase accumulator and one coefficient fetch. The tap count is parametrised and coefficients are signed, so any kernel can be loaded, not only the fixed-sign cubic. Adds selectable line-edge handling, a defined line-start/reset policy and a sticky overrun flag. Sits between the line source and the vertical scaler; coefficient ROM is external.

Parameters:
SCALE_STEP, 4096, fixed-point 1.000 for scale_step_i and the accumulators
CH_COUNT, 3, number of channels carried in parallel on the pixel bus
PIXEL_WIDTH, 8, bits per channel (unsigned)
COE_WIDTH, 10, signed coefficient width; format Q2.(COE_WIDTH-2), 1.0 = 2^(COE_WIDTH-2)
TAP_COUNT, 4, filter taps, 2..8
COE_PHASES, 1024, coefficient sets per input pixel; power of 2, ≤ SCALE_STEP
EDGE_MODE, 1, 0 = unfilled taps read 0 at line start; 1 = replicate first pixel of line

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
scale_step_i  in  16  output pitch in input units; SCALE_STEP = 1:1, larger = downscale
coe_adr_en  out  1  coefficient read strobe
coe_adr  out  log2(COE_PHASES)  phase index
coe_i  in  TAP_COUNT*COE_WIDTH  signed coefficients, tap k at [k*COE_WIDTH +: COE_WIDTH], valid 1 cycle after coe_adr
di_i  in  CH_COUNT*PIXEL_WIDTH  input pixel, channel c at [c*PIXEL_WIDTH +: PIXEL_WIDTH]
de_i, hs_i, vs_i  in  1  input strobes
do_o  out  CH_COUNT*PIXEL_WIDTH  output pixel
de_o, hs_o, vs_o  out  1  output strobes
err_overrun  out  1  sticky input overrun flag

Behaviour:
- Reset (rst_n low at a clk edge): do_o, de_o, hs_o, vs_o, coe_adr_en, err_overrun = 0. Accumulators, window and pipeline are cleared. line_act = 0.
- Reset mid-line: de_o is 0 from the next cycle. No emission occurs until the next hs_i rising edge.
- Line start = hs_i rising edge (hs_i = 1 and the registered hs_i = 0). On this edge: acc_i = 0, acc_o = SCALE_STEP, fill count = 0, line_act = 1.
- Accept: de_i = 1 shifts di_i into the window (tap 0 = newest, tap k = k pixels older), acc_i += SCALE_STEP, fill count increments (saturating at TAP_COUNT).
- Unfilled taps (index ≥ fill count): 0 when EDGE_MODE = 0; the line's first pixel when EDGE_MODE = 1.
- Emission cycle E: the registered condition line_act & (acc_i > acc_o), evaluated every cycle. On E:
  - acc_o += scale_step_i.
  - The window is captured for all channels.
  - coe_adr = acc_o[log2(SCALE_STEP/COE_PHASES) +: log2(COE_PHASES)], using the pre-increment acc_o.
  - coe_adr_en = 1.
- At most one emission per cycle. acc_i and acc_o are 24 bits and wrap modulo 2^24; lines are limited to < 2^24/SCALE_STEP pixels.
- Pipeline:
  - E+1: coe_i sampled; TAP_COUNT×CH_COUNT signed products registered (COE_WIDTH+PIXEL_WIDTH+1 bits).
  - E+2: per-channel sum registered, width grown by ceil(log2(TAP_COUNT)).
  - E+3: rounding and clamp into do_o, de_o = 1.
- de_o is high exactly 3 cycles after each E.
- hs_o and vs_o are hs_i and vs_i delayed by 4 cycles.
- Arithmetic: r = (sum + 2^(COE_WIDTH-3)) >>> (COE_WIDTH-2). do_o = 0 if r < 0; 2^PIXEL_WIDTH-1 if r exceeds that; else r. All channels use identical coefficients.
- Overrun: err_overrun sets when de_i = 1 while acc_i - acc_o > SCALE_STEP, i.e. the input outruns output generation. It stays set until reset. Upstream must keep the de_i duty ≤ scale_step_i/SCALE_STEP for upscale.
- Simultaneous events:
  - hs_i rising edge and de_i in the same cycle: line reset wins and the pixel is dropped.
  - hs_i rising edge with emission pending: the emission proceeds, then the counters reset.
  - The pipeline always drains; outputs in flight still appear.

Test Plan:
1. Unity. scale_step_i = 4096, CH_COUNT = 1, PIXEL_WIDTH = 8, COE_WIDTH = 10, ROM returns tap1 = 256, others 0, EDGE_MODE = 0. Drive an hs pulse, then 10 continuous de_i pixels 0..9 -> exactly 9 de_o pulses, do_o = 0,1,…,8, each 3 cycles after its E; err_overrun stays 0.
2. 2:1 downscale. scale_step_i = 8192, 20 continuous pixels -> 10 de_o pulses. coe_adr sequence matches acc_o = 4096, 12288, 20480… (all phase 0).
3. Clamp. ROM tap0 = 384 (1.5), input 200 -> do_o = 255. ROM tap0 = -256, input 100 -> do_o = 0. Rounding: tap0 = 128, input 3 -> do_o = 2.
4. Edge mode. ROM tap3 = 256, first pixel 50 -> first output 50 with EDGE_MODE = 1, and 0 with EDGE_MODE = 0.
5. Channels. CH_COUNT = 3, inputs {10, 20, 30} constant, tap1 = 256 -> every do_o = {10, 20, 30}.
6. Overrun and reset:
   - scale_step_i = 1024, continuous de_i -> err_overrun = 1 within the first 3 pixels and stays set.
   - Same scale with de_i 1-in-4 -> err_overrun stays 0.
   - Pulse rst_n low 1 cycle mid-line -> err_overrun and de_o = 0 next cycle; no de_o until after the next hs rising edge.
